// File: rtl/tt_um_alu_sequencer.sv
// rtl/tt_um_alu_sequencer.sv - byte-loaded program buffer replayed into the 4-bit ALU with delay-matched result tags
module tt_um_alu_sequencer #(
   parameter int          DEPTH       = 16,
   parameter int          PC_W        = 4,
   parameter int          ALU_LATENCY = 2,
   parameter logic [3:0]  NOP_OP      = 4'hF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_valid,
   input  logic [7:0]      load_data,
   output logic            load_ready,
   input  logic            load_clear,
   input  logic            start,
   input  logic            step_mode,
   input  logic            step,
   input  logic            halt,
   output logic [7:0]      alu_ui,
   output logic [7:0]      alu_uio,
   output logic            busy,
   output logic            done,
   output logic [PC_W:0]   prog_len,
   output logic            res_valid,
   output logic [PC_W-1:0] res_pc
);

   localparam int DCNT_W = $clog2(ALU_LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [12:0]         mem [DEPTH];
   logic [7:0]          byte0;
   logic                byte_phase;
   logic [PC_W-1:0]     pc;
   logic [PC_W-1:0]     issue_pc;
   logic                issue_v;
   logic [DCNT_W-1:0]   drain_cnt;
   logic [ALU_LATENCY-1:0] pipe_v;
   logic [PC_W-1:0]     pipe_pc [ALU_LATENCY];
   logic [12:0]         cur;
   logic                load_fire;
   logic                issue_fire;
   logic                last_entry;
   logic                start_ok;
   logic                unused_bits;

   // entry layout: {end, opcode, B, A}
   assign cur         = mem[pc];
   assign load_fire   = load_valid & load_ready;
   assign start_ok    = (state == S_IDLE) & start & ~byte_phase;
   assign issue_fire  = (state == S_RUN) & ~halt & (~step_mode | step);
   assign last_entry  = cur[12] | ({1'b0, pc} == (prog_len - (PC_W+1)'(1)));
   assign unused_bits = ^load_data[6:4];
   assign res_valid   = pipe_v[ALU_LATENCY-1];
   assign res_pc      = pipe_pc[ALU_LATENCY-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = (prog_len == '0) ? S_DONE : S_RUN;
         S_RUN: begin
            if (halt)                          state_nxt = S_IDLE;
            else if (issue_fire && last_entry) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (halt)                                          state_nxt = S_IDLE;
            else if (drain_cnt == DCNT_W'(ALU_LATENCY - 1))    state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != S_IDLE);
      done       = (state == S_DONE);
      load_ready = (state == S_IDLE) && (prog_len < (PC_W+1)'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_len   <= '0;
         byte_phase <= 1'b0;
         byte0      <= '0;
         pc         <= '0;
         drain_cnt  <= '0;
         issue_v    <= 1'b0;
         issue_pc   <= '0;
         alu_ui     <= '0;
         alu_uio    <= {4'b0, NOP_OP};
      end else begin
         drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
         // clear wins over a byte arriving in the same cycle
         if (state == S_IDLE && load_clear) begin
            prog_len   <= '0;
            byte_phase <= 1'b0;
         end else if (load_fire) begin
            if (!byte_phase) begin
               byte0      <= load_data;
               byte_phase <= 1'b1;
            end else begin
               byte_phase <= 1'b0;
               prog_len   <= prog_len + 1'b1;
            end
         end
         if (start_ok)        pc <= '0;
         else if (issue_fire) pc <= pc + 1'b1;
         issue_v  <= issue_fire;
         issue_pc <= pc;
         if (issue_fire) begin
            alu_ui  <= cur[7:0];
            alu_uio <= {4'b0, cur[11:8]};
         end else begin
            alu_ui  <= '0;
            alu_uio <= {4'b0, NOP_OP};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_fire && byte_phase && !load_clear)
         mem[prog_len[PC_W-1:0]] <= {load_data[7], load_data[3:0], byte0};
   end

   // tag pipe matches the ALU's register delay from its input pins to uo_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         for (int i = 0; i < ALU_LATENCY; i++) pipe_pc[i] <= '0;
      end else begin
         pipe_v[0]  <= issue_v;
         pipe_pc[0] <= issue_pc;
         for (int i = 1; i < ALU_LATENCY; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_pc[i] <= pipe_pc[i-1];
         end
      end
   end

endmodule
